// File: rtl/arb8_bus16.sv
// arb8_bus16: 8-requester round-robin arbiter driving a shared 16-bit bus.
// Each owner keeps the bus for at most HOLD_MAX beats before the grant rotates.
// Optional feature: define ARB8_LOCK_EN so that lock[sel] keeps the current
// owner on the bus past HOLD_MAX until its req drops. When the macro is
// undefined, the lock port is present but has no effect.
module arb8_bus16 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req,
    input  logic [7:0]  lock,
    input  logic [15:0] D0,
    input  logic [15:0] D1,
    input  logic [15:0] D2,
    input  logic [15:0] D3,
    input  logic [15:0] D4,
    input  logic [15:0] D5,
    input  logic [15:0] D6,
    input  logic [15:0] D7,
    input  logic        out_ready,
    output logic [15:0] OUT,
    output logic        out_valid,
    output logic [7:0]  gnt,
    output logic [2:0]  sel,
    output logic        busy
);

    localparam int unsigned NREQ = 8;
    localparam int unsigned SW   = 3;
    localparam int unsigned CW   = 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic            owner_req_c;
    logic            beat_c;
    logic            hold_hit_c;
    logic            release_c;
    logic [NREQ-1:0] arb_req_c;
    logic            win_found_c;
    logic [SW-1:0]   win_idx_c;

    // Round-robin search: first set bit of r starting at index p, wrapping at 8.
    function automatic logic [SW:0] rr_pick(input logic [NREQ-1:0] r, input logic [SW-1:0] p);
        logic          found;
        logic [SW-1:0] idx;
        logic [SW-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = p + SW'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // 8-way 16-bit data mux shared by all requesters.
    function automatic logic [15:0] mux8_16(
        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] d3,
        input logic [15:0] d4, input logic [15:0] d5, input logic [15:0] d6, input logic [15:0] d7,
        input logic [SW-1:0] s
    );
        logic [15:0] y;
        case (s)
            3'd0:    y = d0;
            3'd1:    y = d1;
            3'd2:    y = d2;
            3'd3:    y = d3;
            3'd4:    y = d4;
            3'd5:    y = d5;
            3'd6:    y = d6;
            default: y = d7;
        endcase
        return y;
    endfunction

`ifndef ARB8_LOCK_EN
    // Lock is accepted but intentionally has no effect in this build.
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Bus data follows the current select in every state.
    assign OUT       = mux8_16(D0, D1, D2, D3, D4, D5, D6, D7, sel_q);
    assign busy      = (state_q == GRANT);
    assign out_valid = (state_q == GRANT) && req[sel_q];
    assign gnt       = gnt_q;
    assign sel       = sel_q;

    // Beat accounting and release decision for the current owner.
    always_comb begin
        owner_req_c = req[sel_q];
        beat_c      = (state_q == GRANT) && owner_req_c && out_ready;
`ifdef ARB8_LOCK_EN
        hold_hit_c  = beat_c && (cnt_q == CNT_LAST) && !lock[sel_q];
`else
        hold_hit_c  = beat_c && (cnt_q == CNT_LAST);
`endif
        release_c   = (state_q == GRANT) && (!owner_req_c || hold_hit_c);
    end

    // Arbitration input: a releasing owner is excluded from the same-edge search.
    always_comb begin
        arb_req_c = req;
        if (release_c) begin
            arb_req_c[sel_q] = 1'b0;
        end
        {win_found_c, win_idx_c} = rr_pick(arb_req_c, ptr_q);
    end

    // Next-state and grant update.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d = GRANT;
                    sel_d   = win_idx_c;
                    ptr_d   = win_idx_c + SW'(1);
                    cnt_d   = '0;
                    gnt_d   = NREQ'(1) << win_idx_c;
                end
            end
            GRANT: begin
                if (release_c) begin
                    if (win_found_c) begin
                        sel_d = win_idx_c;
                        ptr_d = win_idx_c + SW'(1);
                        cnt_d = '0;
                        gnt_d = NREQ'(1) << win_idx_c;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (beat_c) begin
                    // Saturate so a locked owner releases on the first beat after unlock.
                    cnt_d = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

endmodule
